picoblaze_sample_feeder: RTL and testbench

- Sits directly upstream of the PicoBlaze/Pacoblaze LED-meter controller in the iPod player.
- Takes the stream of signed 16-bit audio samples, finds the peak magnitude over a window of DECIM samples, and presents it as an 8-bit level on the processor's input port 0.
- When each window completes, raises `interrupt` and holds it until the processor acknowledges it, or until a timeout expires.
- Flags overrun when a new window completes while the previous interrupt is still pending.

---
 rtl/picoblaze_sample_feeder.sv | 101 ++++++++++
 tb/tb_picoblaze_sample_feeder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/picoblaze_sample_feeder.sv
// Windowed peak-magnitude detector feeding the LED-meter PicoBlaze input port 0,
// with a level interrupt that clears on acknowledge or timeout and a sticky overrun flag.
module picoblaze_sample_feeder #(
  parameter int unsigned DECIM       = 256,
  parameter int unsigned INT_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  input  logic        interrupt_ack,
  input  logic        clear_overrun,
  output logic [7:0]  input_data,
  output logic        interrupt,
  output logic        overrun,
  output logic [15:0] window_count
);

  typedef enum logic {S_IDLE, S_PENDING} state_t;

  localparam logic [15:0] LAST_IDX = 16'(DECIM - 1);
  localparam logic [31:0] TO_LAST  = 32'(INT_TIMEOUT - 1);
  localparam bit          TO_EN    = (INT_TIMEOUT != 0);

  state_t      r_state;
  logic [14:0] r_peak;
  logic [15:0] r_count;
  logic [7:0]  r_level;
  logic [31:0] r_timer;
  logic        r_interrupt;
  logic        r_overrun;

  logic [15:0] w_abs;
  logic [14:0] w_mag;
  logic [14:0] w_peak_next;
  logic        w_done;
  logic        w_ovr_set;

  // Only -32768 has bit 15 set after negation; it saturates to 32767.
  always_comb begin
    w_abs       = sample_data[15] ? (~sample_data + 16'd1) : sample_data;
    w_mag       = w_abs[15] ? 15'h7FFF : w_abs[14:0];
    w_peak_next = (w_mag > r_peak) ? w_mag : r_peak;
    w_done      = sample_valid && (r_count == LAST_IDX);
    w_ovr_set   = w_done && (r_state == S_PENDING) && !interrupt_ack;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_peak      <= '0;
      r_count     <= '0;
      r_level     <= '0;
      r_timer     <= '0;
      r_interrupt <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (sample_valid) begin
        if (w_done) begin
          r_level <= w_peak_next[14:7];
          r_peak  <= '0;
          r_count <= '0;
        end else begin
          r_peak  <= w_peak_next;
          r_count <= r_count + 16'd1;
        end
      end

      // A new window-done always (re)arms the interrupt, even over an ack or timeout.
      case (r_state)
        S_IDLE: begin
          if (w_done) begin
            r_state     <= S_PENDING;
            r_timer     <= '0;
            r_interrupt <= 1'b1;
          end
        end
        S_PENDING: begin
          if (w_done) begin
            r_timer <= '0;
          end else if (interrupt_ack || (TO_EN && (r_timer == TO_LAST))) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_interrupt <= 1'b0;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
      endcase

      if (w_ovr_set)          r_overrun <= 1'b1;
      else if (clear_overrun) r_overrun <= 1'b0;
    end
  end

  assign input_data   = r_level;
  assign interrupt    = r_interrupt;
  assign overrun      = r_overrun;
  assign window_count = r_count;

endmodule

// File: tb/tb_picoblaze_sample_feeder.sv
// Bench for picoblaze_sample_feeder: directed sequences (DECIM=256), a level table
// (DECIM=1, INT_TIMEOUT=8) and randomized traffic against a window-queue model (DECIM=5).
module tb_picoblaze_sample_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: defaults
  logic        a_reset = 1'b1, a_valid = 1'b0, a_ack = 1'b0, a_clr = 1'b0;
  logic [15:0] a_data = '0;
  logic [7:0]  a_level;
  logic        a_int, a_ovr;
  logic [15:0] a_cnt;

  picoblaze_sample_feeder dut_a (
    .clk(clk), .reset(a_reset), .sample_valid(a_valid), .sample_data(a_data),
    .interrupt_ack(a_ack), .clear_overrun(a_clr),
    .input_data(a_level), .interrupt(a_int), .overrun(a_ovr), .window_count(a_cnt)
  );

  // Instance B: every sample is a window, short timeout
  logic        b_reset = 1'b1, b_valid = 1'b0, b_ack = 1'b0, b_clr = 1'b0;
  logic [15:0] b_data = '0;
  logic [7:0]  b_level;
  logic        b_int, b_ovr;
  logic [15:0] b_cnt;

  picoblaze_sample_feeder #(.DECIM(1), .INT_TIMEOUT(8)) dut_b (
    .clk(clk), .reset(b_reset), .sample_valid(b_valid), .sample_data(b_data),
    .interrupt_ack(b_ack), .clear_overrun(b_clr),
    .input_data(b_level), .interrupt(b_int), .overrun(b_ovr), .window_count(b_cnt)
  );

  // Instance C: randomized against the model
  localparam int C_DECIM = 5;
  localparam int C_TO    = 6;
  logic        c_reset = 1'b1, c_valid = 1'b0, c_ack = 1'b0, c_clr = 1'b0;
  logic [15:0] c_data = '0;
  logic [7:0]  c_level;
  logic        c_int, c_ovr;
  logic [15:0] c_cnt;

  picoblaze_sample_feeder #(.DECIM(C_DECIM), .INT_TIMEOUT(C_TO)) dut_c (
    .clk(clk), .reset(c_reset), .sample_valid(c_valid), .sample_data(c_data),
    .interrupt_ack(c_ack), .clear_overrun(c_clr),
    .input_data(c_level), .interrupt(c_int), .overrun(c_ovr), .window_count(c_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic a_samples(input int n, input logic [15:0] d);
    for (int i = 0; i < n; i++) begin
      a_valid = 1'b1;
      a_data  = d;
      tick();
    end
    a_valid = 1'b0;
  endtask

  // Reference model: the current window is a queue of magnitudes.
  int m_q[$];
  int m_level;
  bit m_pend;
  int m_age;
  bit m_ovr;

  function automatic int mag_of(input logic [15:0] d);
    int v;
    v = int'($signed(d));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  task automatic model_step();
    bit done;
    int pk;
    if (c_reset) begin
      m_q.delete();
      m_level = 0; m_pend = 0; m_age = 0; m_ovr = 0;
      return;
    end
    done = 0;
    if (c_valid) begin
      m_q.push_back(mag_of(c_data));
      if (m_q.size() == C_DECIM) begin
        pk = 0;
        foreach (m_q[k]) if (m_q[k] > pk) pk = m_q[k];
        m_level = pk / 128;
        m_q.delete();
        done = 1;
      end
    end
    if (done) begin
      if (m_pend && !c_ack) m_ovr = 1;
      else if (c_clr) m_ovr = 0;
      m_pend = 1;
      m_age  = 0;
    end else begin
      if (c_clr) m_ovr = 0;
      if (m_pend) begin
        if (c_ack || (m_age == C_TO - 1)) m_pend = 0;
        else m_age++;
      end
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic [7:0]  exp_level;
  } vec_t;

  vec_t vt[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vt[0] = '{16'h8000, 8'hFF};
    vt[1] = '{16'h7FFF, 8'hFF};
    vt[2] = '{16'hFFFF, 8'h00};
    vt[3] = '{16'h0080, 8'h01};
    vt[4] = '{16'hFF80, 8'h01};
    vt[5] = '{16'hC000, 8'h80};
    vt[6] = '{16'h3FFF, 8'h7F};
    vt[7] = '{16'hC001, 8'h7F};

    // ---------------- Instance A: directed ----------------
    tick();
    check("a_rst_level", a_level, 0);
    check("a_rst_int",   a_int,   0);
    check("a_rst_ovr",   a_ovr,   0);
    check("a_rst_cnt",   a_cnt,   0);
    a_reset = 1'b0;

    a_samples(100, 16'h0100);
    a_samples(1,   16'hC000);
    a_samples(154, 16'h0100);
    check("a_w1_cnt255", a_cnt, 255);
    check("a_w1_noint",  a_int, 0);
    a_samples(1, 16'h0100);
    check("a_w1_level", a_level, 8'h80);
    check("a_w1_int",   a_int,   1);
    check("a_w1_cnt0",  a_cnt,   0);

    for (int i = 0; i < 5; i++) tick();
    check("a_hold_int", a_int, 1);
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    check("a_ack_int", a_int, 0);
    check("a_ack_ovr", a_ovr, 0);
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    check("a_idle_ack_int", a_int, 0);

    a_samples(256, 16'h0100);
    check("a_w2_level", a_level, 8'h02);
    check("a_w2_int",   a_int,   1);
    check("a_w2_ovr",   a_ovr,   0);
    a_samples(10, 16'h0100);
    a_samples(1,  16'h7FFF);
    a_samples(245, 16'h0100);
    check("a_w3_int",   a_int,   1);
    check("a_w3_level", a_level, 8'hFF);
    check("a_w3_ovr",   a_ovr,   1);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check("a_clr_ovr", a_ovr, 0);
    check("a_clr_int", a_int, 1);
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    check("a_w3_ack", a_int, 0);

    a_samples(256, 16'h0100);
    check("a_w4_int", a_int, 1);
    a_samples(255, 16'h0100);
    a_ack = 1'b1;
    a_samples(1, 16'h0100);
    a_ack = 1'b0;
    check("a_coinc_int", a_int, 1);
    check("a_coinc_ovr", a_ovr, 0);
    tick();
    check("a_coinc_int2", a_int, 1);

    a_samples(50, 16'h4000);
    check("a_mid_cnt", a_cnt, 50);
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0;
    check("a_mid_rst_level", a_level, 0);
    check("a_mid_rst_int",   a_int,   0);
    check("a_mid_rst_ovr",   a_ovr,   0);
    check("a_mid_rst_cnt",   a_cnt,   0);
    a_samples(255, 16'h0100);
    check("a_post_cnt",   a_cnt, 255);
    check("a_post_noint", a_int, 0);
    a_samples(1, 16'h0100);
    check("a_post_int",   a_int,   1);
    check("a_post_level", a_level, 8'h02);

    // ---------------- Instance B: level table ----------------
    b_reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b_valid = 1'b1;
      b_data  = vt[i].data;
      tick();
      b_valid = 1'b0;
      check($sformatf("b_vec%0d_level", i), b_level, vt[i].exp_level);
      check($sformatf("b_vec%0d_int", i),   b_int,   1);
      check($sformatf("b_vec%0d_cnt", i),   b_cnt,   0);
      b_ack = 1'b1;
      tick();
      b_ack = 1'b0;
      check($sformatf("b_vec%0d_ack", i), b_int, 0);
    end

    b_valid = 1'b1;
    b_data  = 16'h1000;
    tick();
    b_valid = 1'b0;
    n = 0;
    while (b_int && n < 50) begin
      n++;
      tick();
    end
    check("b_timeout_len", n, 8);
    check("b_timeout_level", b_level, 8'h20);

    // ---------------- Instance C: randomized vs model ----------------
    for (int cyc = 0; cyc < 3000; cyc++) begin
      c_reset = (cyc == 0) || ($urandom_range(0, 299) == 0);
      c_valid = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 7))
        0: c_data = 16'h8000;
        1: c_data = 16'h7FFF;
        2: c_data = 16'h0000;
        default: c_data = 16'($urandom);
      endcase
      c_ack = ($urandom_range(0, 7) == 0);
      c_clr = ($urandom_range(0, 15) == 0);
      model_step();
      tick();
      check("c_level", c_level, m_level);
      check("c_int",   c_int,   m_pend);
      check("c_ovr",   c_ovr,   m_ovr);
      check("c_cnt",   c_cnt,   m_q.size());
    end
    c_valid = 1'b0;
    c_ack   = 1'b0;
    c_clr   = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
